// File: rtl/winddir_avg_pkg.sv
// Shared constants and FSM state type for the wind-direction circular averager.
// Angles are signed degrees with 10 fractional bits.
package winddir_avg_pkg;

    localparam int ANGLE_W = 19;
    localparam int FRAC_W  = 10;
    localparam int DEG180  = 184320;
    localparam int DEG360  = 368640;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_FOLD = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/winddir_avg_if.sv
// Sample/result bus of winddir_avg. The spread port exists only when
// WINDDIR_AVG_SPREAD_EN is defined.
interface winddir_avg_if;
    import winddir_avg_pkg::*;

    logic                      enable;
    logic                      clear;
    logic signed [ANGLE_W-1:0] angle_in;
    logic                      angle_valid;
    logic [ANGLE_W-1:0]        dir_out;
    logic                      dir_valid;
    logic                      busy;
    logic                      overrun;
`ifdef WINDDIR_AVG_SPREAD_EN
    logic [ANGLE_W-1:0]        spread;

    modport master (output enable, clear, angle_in, angle_valid,
                    input  dir_out, dir_valid, busy, overrun, spread);
    modport slave  (input  enable, clear, angle_in, angle_valid,
                    output dir_out, dir_valid, busy, overrun, spread);
`else
    modport master (output enable, clear, angle_in, angle_valid,
                    input  dir_out, dir_valid, busy, overrun);
    modport slave  (input  enable, clear, angle_in, angle_valid,
                    output dir_out, dir_valid, busy, overrun);
`endif

endinterface

// File: rtl/winddir_avg_angle_fold.sv
// angle_fold: combinational wrap of a signed angle into [LO, LO+360 deg),
// correcting by at most one full turn.
module winddir_avg_angle_fold
    import winddir_avg_pkg::*;
#(
    parameter int W  = 20,
    parameter int LO = 0
) (
    input  logic signed [W-1:0] i_angle,
    output logic signed [W-1:0] o_angle
);

    localparam logic signed [W-1:0] LO_C   = W'(LO);
    localparam logic signed [W-1:0] HI_C   = W'(LO + DEG360);
    localparam logic signed [W-1:0] SPAN_C = W'(DEG360);

    always_comb begin
        o_angle = i_angle;
        if (i_angle >= HI_C) begin
            o_angle = i_angle - SPAN_C;
        end else if (i_angle < LO_C) begin
            o_angle = i_angle + SPAN_C;
        end
    end

endmodule

// File: rtl/winddir_avg.sv
// Circular mean of N = 2^LOG2N wind-direction samples, using deviations from the
// first sample of each window. Optional spread tracker: WINDDIR_AVG_SPREAD_EN.
module winddir_avg
    import winddir_avg_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    winddir_avg_if.slave  io_bus
);

    localparam int DEV_W = ANGLE_W + 1;
    localparam int ACC_W = 20 + LOG2N;
    localparam int CNT_W = LOG2N + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2N) - 1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]   r_sum;
    logic signed [ANGLE_W-1:0] r_ref;
    logic [ANGLE_W-1:0]        r_mean;
    logic [ANGLE_W-1:0]        r_dir_out;
    logic                      r_dir_valid;
    logic                      r_busy;
    logic                      r_overrun;

    logic                      w_first;
    logic                      w_accept;
    logic signed [ANGLE_W-1:0] w_ref_eff;
    logic signed [DEV_W-1:0]   w_dev_raw;
    logic signed [DEV_W-1:0]   w_dev;
    logic signed [ACC_W-1:0]   w_sum_next;
    logic signed [DEV_W-1:0]   w_sum_avg;
    logic signed [DEV_W-1:0]   w_mean_raw;
    logic signed [DEV_W-1:0]   w_mean;

    assign w_first  = (r_cnt == '0);
    assign w_accept = io_bus.enable && io_bus.angle_valid && !io_bus.clear
                      && (r_state == ST_ACC);

    // The first sample of a window is its own reference, so its deviation is 0.
    assign w_ref_eff = w_first ? io_bus.angle_in : r_ref;
    assign w_dev_raw = {io_bus.angle_in[ANGLE_W-1], io_bus.angle_in}
                     - {w_ref_eff[ANGLE_W-1], w_ref_eff};

    winddir_avg_angle_fold #(.W(DEV_W), .LO(-DEG180)) u_dev_fold (
        .i_angle (w_dev_raw),
        .o_angle (w_dev)
    );

    assign w_sum_next = (w_first ? ACC_W'(0) : r_sum) + ACC_W'(w_dev);

    // Arithmetic shift floors the mean deviation toward minus infinity.
    assign w_sum_avg  = DEV_W'(r_sum >>> LOG2N);
    assign w_mean_raw = {r_ref[ANGLE_W-1], r_ref} + w_sum_avg;

    winddir_avg_angle_fold #(.W(DEV_W), .LO(0)) u_mean_fold (
        .i_angle (w_mean_raw),
        .o_angle (w_mean)
    );

`ifdef WINDDIR_AVG_SPREAD_EN
    logic [ANGLE_W-1:0] r_spread;
    logic [ANGLE_W-1:0] r_spread_max;
    logic [ANGLE_W-1:0] w_dev_abs;

    assign w_dev_abs = ANGLE_W'(w_dev[DEV_W-1] ? -w_dev : w_dev);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_spread_max <= '0;
            r_spread     <= '0;
        end else if (io_bus.clear) begin
            r_spread_max <= '0;
        end else if (w_accept) begin
            if (w_first || (w_dev_abs > r_spread_max)) begin
                r_spread_max <= w_dev_abs;
            end
        end else if ((r_state == ST_OUT) && io_bus.enable) begin
            r_spread <= r_spread_max;
        end
    end

    assign io_bus.spread = r_spread;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_ACC;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_ref       <= '0;
            r_mean      <= '0;
            r_dir_out   <= '0;
            r_dir_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_dir_valid <= 1'b0;
            if (io_bus.clear) begin
                r_state   <= ST_ACC;
                r_busy    <= 1'b0;
                r_cnt     <= '0;
                r_sum     <= '0;
                r_ref     <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (io_bus.enable && io_bus.angle_valid && (r_state != ST_ACC)) begin
                    r_overrun <= 1'b1;
                end
                case (r_state)
                    ST_ACC: begin
                        if (w_accept) begin
                            r_sum <= w_sum_next;
                            if (w_first) begin
                                r_ref <= io_bus.angle_in;
                            end
                            if (r_cnt == LAST_CNT) begin
                                r_cnt   <= '0;
                                r_state <= ST_FOLD;
                                r_busy  <= 1'b1;
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_FOLD: begin
                        if (io_bus.enable) begin
                            r_mean  <= ANGLE_W'(w_mean);
                            r_state <= ST_OUT;
                        end
                    end
                    ST_OUT: begin
                        if (io_bus.enable) begin
                            r_dir_out   <= r_mean;
                            r_dir_valid <= 1'b1;
                            r_state     <= ST_ACC;
                            r_busy      <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_ACC;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_bus.dir_out   = r_dir_out;
    assign io_bus.dir_valid = r_dir_valid;
    assign io_bus.busy      = r_busy;
    assign io_bus.overrun   = r_overrun;

endmodule

// File: tb/tb_winddir_avg.sv
// Directed bench for winddir_avg (LOG2N=3); spread checks active with WINDDIR_AVG_SPREAD_EN.
module tb_winddir_avg;
    import winddir_avg_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;

    winddir_avg_if bus ();

    winddir_avg #(.LOG2N(3)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.dir_valid === 1'b1) pulses++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send(input int v);
        @(negedge clk);
        bus.enable      = 1'b1;
        bus.angle_in    = 19'(v);
        bus.angle_valid = 1'b1;
    endtask

    // Drops valid and waits (bounded) for the next dir_valid pulse.
    task automatic wait_out(output int lat, output logic [18:0] d, output logic [18:0] sp);
        lat = -1;
        d   = '0;
        sp  = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.angle_valid = 1'b0;
            if (bus.dir_valid === 1'b1) begin
                lat = k;
                d   = bus.dir_out;
`ifdef WINDDIR_AVG_SPREAD_EN
                sp  = bus.spread;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.enable      = 1'b1;
        bus.clear       = 1'b0;
        bus.angle_in    = '0;
        bus.angle_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.dir_out !== 19'd0) begin errors++; $display("FAIL reset_dir_out: got %0d expected 0", bus.dir_out); end
        checks++; if (bus.dir_valid !== 1'b0) begin errors++; $display("FAIL reset_dir_valid: got %b expected 0", bus.dir_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
`ifdef WINDDIR_AVG_SPREAD_EN
        checks++; if (bus.spread !== 19'd0) begin errors++; $display("FAIL reset_spread: got %0d expected 0", bus.spread); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_const45();
        int p0 = pulses;
        for (int i = 0; i < 8; i++) send(46080);
        @(negedge clk);
        bus.angle_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL c45_busy_fold: got %b expected 1", bus.busy); end
        checks++; if (bus.dir_valid !== 1'b0) begin errors++; $display("FAIL c45_valid_fold: got %b expected 0", bus.dir_valid); end
        @(negedge clk);
        checks++; if (bus.dir_valid !== 1'b0) begin errors++; $display("FAIL c45_valid_out: got %b expected 0", bus.dir_valid); end
        @(negedge clk);
        checks++; if (bus.dir_valid !== 1'b1) begin errors++; $display("FAIL c45_valid_lat2: got %b expected 1", bus.dir_valid); end
        checks++; if (bus.dir_out !== 19'd46080) begin errors++; $display("FAIL c45_dir_out: got %0d expected 46080", bus.dir_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL c45_busy_done: got %b expected 0", bus.busy); end
`ifdef WINDDIR_AVG_SPREAD_EN
        checks++; if (bus.spread !== 19'd0) begin errors++; $display("FAIL c45_spread: got %0d expected 0", bus.spread); end
`endif
        @(negedge clk);
        checks++; if (bus.dir_valid !== 1'b0) begin errors++; $display("FAIL c45_valid_width: got %b expected 0", bus.dir_valid); end
        checks++; if (bus.dir_out !== 19'd46080) begin errors++; $display("FAIL c45_dir_hold: got %0d expected 46080", bus.dir_out); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL c45_pulse_count: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_wrap180();
        int lat; logic [18:0] d; logic [18:0] sp;
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 183296 : -183296);
        wait_out(lat, d, sp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL w180_latency: got %0d expected 2", lat); end
        checks++; if (d !== 19'd184320) begin errors++; $display("FAIL w180_dir_out: got %0d expected 184320", d); end
`ifdef WINDDIR_AVG_SPREAD_EN
        checks++; if (sp !== 19'd2048) begin errors++; $display("FAIL w180_spread: got %0d expected 2048", sp); end
`endif
    endtask

    task automatic test_neg90();
        int lat; logic [18:0] d; logic [18:0] sp;
        for (int i = 0; i < 8; i++) send(-92160);
        wait_out(lat, d, sp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL n90_latency: got %0d expected 2", lat); end
        checks++; if (d !== 19'd276480) begin errors++; $display("FAIL n90_dir_out: got %0d expected 276480", d); end
    endtask

    task automatic test_boundary();
        int lat; logic [18:0] d; logic [18:0] sp;
        for (int i = 0; i < 8; i++) send((i % 2 == 0) ? -184320 : 184320);
        wait_out(lat, d, sp);
        checks++; if (d !== 19'd184320) begin errors++; $display("FAIL bnd_pm180_dir: got %0d expected 184320", d); end
`ifdef WINDDIR_AVG_SPREAD_EN
        checks++; if (sp !== 19'd0) begin errors++; $display("FAIL bnd_pm180_spread: got %0d expected 0", sp); end
`endif
        send(0);
        for (int i = 0; i < 7; i++) send(-1);
        wait_out(lat, d, sp);
        checks++; if (d !== 19'd368639) begin errors++; $display("FAIL bnd_floor_dir: got %0d expected 368639", d); end
`ifdef WINDDIR_AVG_SPREAD_EN
        checks++; if (sp !== 19'd1) begin errors++; $display("FAIL bnd_floor_spread: got %0d expected 1", sp); end
`endif
    endtask

    task automatic test_enable();
        for (int i = 0; i < 4; i++) send(40960);
        @(negedge clk);
        bus.enable      = 1'b0;
        bus.angle_in    = 19'(-184320);
        bus.angle_valid = 1'b1;
        for (int i = 0; i < 4; i++) send(40960);
        @(negedge clk);
        bus.angle_valid = 1'b0;
        bus.enable      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL en_frozen_busy%0d: got %b expected 1", i, bus.busy); end
            checks++; if (bus.dir_valid !== 1'b0) begin errors++; $display("FAIL en_frozen_valid%0d: got %b expected 0", i, bus.dir_valid); end
        end
        bus.enable = 1'b1;
        @(negedge clk);
        checks++; if (bus.dir_valid !== 1'b0) begin errors++; $display("FAIL en_resume_early: got %b expected 0", bus.dir_valid); end
        @(negedge clk);
        checks++; if (bus.dir_valid !== 1'b1) begin errors++; $display("FAIL en_resume_valid: got %b expected 1", bus.dir_valid); end
        checks++; if (bus.dir_out !== 19'd40960) begin errors++; $display("FAIL en_dir_out: got %0d expected 40960", bus.dir_out); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL en_no_overrun: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) send(20480);
        @(negedge clk);
        bus.angle_in    = 19'd0;
        bus.angle_valid = 1'b1;
        @(negedge clk);
        bus.angle_valid = 1'b0;
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", bus.overrun); end
        @(negedge clk);
        checks++; if (bus.dir_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", bus.dir_valid); end
        checks++; if (bus.dir_out !== 19'd20480) begin errors++; $display("FAIL ovr_dir_out: got %0d expected 20480", bus.dir_out); end
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared: got %b expected 0", bus.overrun); end
        checks++; if (bus.dir_out !== 19'd20480) begin errors++; $display("FAIL ovr_dir_kept: got %0d expected 20480", bus.dir_out); end
    endtask

    task automatic test_clear_last();
        int lat; logic [18:0] d; logic [18:0] sp;
        int p0 = pulses;
        for (int i = 0; i < 7; i++) send(30720);
        @(negedge clk);
        bus.angle_in    = 19'd30720;
        bus.angle_valid = 1'b1;
        bus.clear       = 1'b1;
        @(negedge clk);
        bus.angle_valid = 1'b0;
        bus.clear       = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL clr8_no_output: got %0d pulses expected 0", pulses - p0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL clr8_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.dir_out !== 19'd20480) begin errors++; $display("FAIL clr8_dir_kept: got %0d expected 20480", bus.dir_out); end
        for (int i = 0; i < 8; i++) send(-10240);
        wait_out(lat, d, sp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL clr8_next_latency: got %0d expected 2", lat); end
        checks++; if (d !== 19'd358400) begin errors++; $display("FAIL clr8_next_dir: got %0d expected 358400", d); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL clr8_next_count: got %0d expected 1", pulses - p0); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [18:0] d; logic [18:0] sp;
        int p0;
        for (int i = 0; i < 5; i++) send(12345);
        @(negedge clk);
        bus.angle_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.dir_out !== 19'd0) begin errors++; $display("FAIL rmid_async_dir: got %0d expected 0", bus.dir_out); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_async_busy: got %b expected 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 8; i++) send(10240);
        wait_out(lat, d, sp);
        checks++; if (lat !== 2) begin errors++; $display("FAIL rmid_latency: got %0d expected 2", lat); end
        checks++; if (d !== 19'd10240) begin errors++; $display("FAIL rmid_dir_out: got %0d expected 10240", d); end
        checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL rmid_pulse_count: got %0d expected 1", pulses - p0); end
`ifdef WINDDIR_AVG_SPREAD_EN
        checks++; if (sp !== 19'd0) begin errors++; $display("FAIL rmid_spread: got %0d expected 0", sp); end
`endif
    endtask

    initial begin
        test_reset();
        test_const45();
        test_wrap180();
        test_neg90();
        test_boundary();
        test_enable();
        test_overrun();
        test_clear_last();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/winddir_avg.md
WINDDIR_AVG -- requirements
Module: winddir_avg

Interface
REQ-001 Parameter LOG2N, 3, log2 of the window length N (N = 2^LOG2N, LOG2N range 1..6).
REQ-002 clock  input  1  system clock, all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  when low, no sample is accepted and the FSM holds its state.
REQ-005 clear  input  1  synchronous window restart, ignored while reset is asserted.
REQ-006 angle_in  input  19  signed angle in degrees with 10 fractional bits, from the upstream rec2pol stage, valid range [-184320, 184320].
REQ-007 angle_valid  input  1  one-cycle strobe marking angle_in valid.
REQ-008 dir_out  output  19  unsigned mean direction in degrees with 10 fractional bits, range [0, 368639].
REQ-009 dir_valid  output  1  one-cycle strobe marking a new dir_out.
REQ-010 busy  output  1  high in states FOLD and OUT.
REQ-011 overrun  output  1  sticky flag; a sample was dropped.
REQ-012 spread  output  19  unsigned max |folded deviation| in the last window; present only with WINDDIR_AVG_SPREAD_EN.

Function
REQ-013 The FSM shall have three states: ACC, FOLD and OUT; it shall transition ACC->FOLD on acceptance of sample N, FOLD->OUT on the next cycle, and OUT->ACC on the next cycle.
REQ-014 A sample shall be accepted only when enable=1, angle_valid=1, state=ACC and clear=0.
REQ-015 The first accepted sample of a window shall be stored as ref and shall contribute deviation 0.
REQ-016 For each sample, d = angle_in - ref shall be computed, then folded: if d >= 184320 subtract 368640; if d < -184320 add 368640.
REQ-017 Folded d shall be summed in a signed accumulator of 20+LOG2N bits; no overflow is permitted.
REQ-018 In FOLD: m = ref + (sum >>> LOG2N), using an arithmetic shift (floor); m shall then be folded into [0, 368640) by adding or subtracting 368640 at most once.
REQ-019 In OUT: dir_out shall be loaded with m and dir_valid=1 for exactly one cycle; dir_valid rises 2 cycles after the edge that accepted sample N.
REQ-020 dir_out shall hold its value until the next OUT.
REQ-021 A sample with angle_valid=1 and enable=1 arriving in FOLD or OUT shall be dropped and shall set overrun.
REQ-022 clear=1 shall reset the sample counter, sum and ref, force state ACC, and clear overrun.
REQ-023 clear shall not alter dir_out; if clear coincides with sample N, the sample is discarded and no output is produced.
REQ-024 The sample counter (LOG2N+1 bits) shall wrap to 0 on the FOLD transition.
REQ-025 enable=0 in FOLD or OUT shall freeze the FSM; dir_valid shall be produced only when OUT is executed with enable=1.

Reset
REQ-026 reset low shall immediately force: state ACC, counter 0, sum 0, ref 0, dir_out 0, dir_valid 0, busy 0, overrun 0, spread 0.
REQ-027 Reset mid-window shall discard all partial accumulation; the first accepted sample after release starts a new window.

Configuration
REQ-028 With WINDDIR_AVG_SPREAD_EN defined, the block shall track max |folded d| per window; spread shall be loaded in OUT together with dir_out, and the tracker cleared at window start.
REQ-029 Without WINDDIR_AVG_SPREAD_EN, the spread port and its logic shall be absent.

Structure
REQ-030 A shared package shall hold: the angle width (19), the fraction bits (10), the constants DEG180=184320 and DEG360=368640, and the FSM state enum.
REQ-031 A sub-module angle_fold (combinational wrap into a half-open range) shall be instantiated for both the deviation fold and the output fold.

Verification
REQ-032 LOG2N=3, 8 samples of 46080 (45 deg) -> dir_out=46080, dir_valid pulse 2 cycles after the 8th sample, spread=0.
REQ-033 8 samples alternating 183296/-183296 (+/-179 deg) -> dir_out=184320 (180 deg), spread=2048.
REQ-034 8 samples of -92160 (-90 deg) -> dir_out=276480 (270 deg).
REQ-035 Reset asserted after 5 samples, then 8 samples of 10240 -> single dir_out=10240.
REQ-036 Sample presented in the FOLD cycle -> sample ignored, overrun=1; clear pulse -> overrun=0, dir_out unchanged.
REQ-037 clear asserted with sample 8 -> no dir_valid; the next 8 samples produce a normal output.
